jk_cmd_gen: RTL and testbench

JK_CMD_GEN -- requirements
Module: jk_cmd_gen

---
 rtl/jk_pkg.sv | 29 ++
 rtl/jk_debounce.sv | 40 ++++
 rtl/jk_cmd_gen.sv | 70 +++++++
 tb/tb_jk_cmd_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared types for the JK command generator: FSM states, command codes, button bundle.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ISSUE        = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_e;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_CLR  = 2'b01;
  localparam logic [1:0] CMD_SET  = 2'b10;
  localparam logic [1:0] CMD_TOG  = 2'b11;

  typedef struct packed {
    logic tog;
    logic clr;
    logic set;
  } btn_t;

  // Simultaneous set+clr is treated as a toggle, as is any tog press.
  function automatic logic [1:0] encode_cmd(input btn_t press);
    if (press.tog || (press.set && press.clr)) return CMD_TOG;
    if (press.set) return CMD_SET;
    if (press.clr) return CMD_CLR;
    return CMD_HOLD;
  endfunction

endpackage

// File: rtl/jk_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer; emits a one-cycle press pulse.
module jk_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_BITS = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic [1:0]          sync;
  logic [CNT_BITS-1:0] cnt;

  // Counter only advances while the synchronised input disagrees with the held level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b00;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync[1];
        press <= sync[1];
      end else begin
        cnt <= cnt + CNT_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/jk_cmd_gen.sv
// Turns three debounced push-buttons into single-cycle J/K commands for a downstream JK flip-flop.
module jk_cmd_gen
  import jk_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_set,
  input  logic             btn_clr,
  input  logic             btn_tog,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic [CNT_W-1:0] cmd_count
);

  btn_t   level;
  btn_t   press;
  state_e state;

  jk_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
    .clk(clk), .rst_n(rst_n), .raw(btn_set), .level(level.set), .press(press.set)
  );
  jk_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk(clk), .rst_n(rst_n), .raw(btn_clr), .level(level.clr), .press(press.clr)
  );
  jk_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_tog (
    .clk(clk), .rst_n(rst_n), .raw(btn_tog), .level(level.tog), .press(press.tog)
  );

  // One command per press; later presses are dropped until every button is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      j         <= 1'b0;
      k         <= 1'b0;
      busy      <= 1'b0;
      cmd_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (press != btn_t'(3'b000)) begin
            state  <= ISSUE;
            {j, k} <= encode_cmd(press);
            busy   <= 1'b1;
          end
        end
        ISSUE: begin
          state     <= WAIT_RELEASE;
          {j, k}    <= CMD_HOLD;
          cmd_count <= cmd_count + CNT_W'(1);
        end
        WAIT_RELEASE: begin
          if (level == btn_t'(3'b000)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          {j, k} <= CMD_HOLD;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_cmd_gen.sv
// Self-checking bench for jk_cmd_gen: vector table, directed corner sequences, random stimulus vs model.
module tb_jk_cmd_gen;

  localparam int unsigned DB = 4;
  localparam int unsigned CW = 2;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          btn_set = 1'b0;
  logic          btn_clr = 1'b0;
  logic          btn_tog = 1'b0;
  logic          j;
  logic          k;
  logic          busy;
  logic [CW-1:0] cmd_count;

  jk_cmd_gen #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .btn_set(btn_set), .btn_clr(btn_clr), .btn_tog(btn_tog),
    .j(j), .k(k), .busy(busy), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int npulse = 0;
  logic [1:0]    lastjk = 2'b00;
  logic [CW-1:0] exp_cnt = '0;

  // Reference model: raw sample history, window-based debounce, command phases.
  bit [2:0]    hist[$];
  bit [2:0]    lvl;
  bit [2:0]    rose;
  bit          m_issue;
  bit          m_wait;
  bit [1:0]    m_jk;
  bit [CW-1:0] m_cnt;

  typedef struct {
    bit [2:0] btn;
    int       hold;
    int       pulses;
    bit [1:0] jk;
  } vec_t;

  vec_t vecs[9];
  int   wrap_exp[4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < int'(DB) + 2; i++) hist.push_back(3'b000);
    lvl = 3'b000; rose = 3'b000;
    m_issue = 1'b0; m_wait = 1'b0; m_jk = 2'b00; m_cnt = '0;
  endtask

  task automatic model_edge(input bit [2:0] raw);
    bit [2:0] nrose;
    bit       flip;
    if (m_issue) begin
      m_issue = 1'b0; m_wait = 1'b1; m_jk = 2'b00; m_cnt = m_cnt + CW'(1);
    end else if (m_wait) begin
      if (lvl == 3'b000) m_wait = 1'b0;
    end else if (rose != 3'b000) begin
      m_issue = 1'b1;
      if (rose[2] || (rose[0] && rose[1])) m_jk = 2'b11;
      else if (rose[0])                    m_jk = 2'b10;
      else                                 m_jk = 2'b01;
    end
    // A level flips once the D synchronised samples (2 edges late) all disagree with it.
    hist.push_back(raw);
    nrose = 3'b000;
    for (int b = 0; b < 3; b++) begin
      flip = 1'b1;
      for (int i = 1; i <= int'(DB); i++) if (hist[i][b] == lvl[b]) flip = 1'b0;
      if (flip) begin
        lvl[b]   = ~lvl[b];
        nrose[b] = lvl[b];
      end
    end
    void'(hist.pop_front());
    rose = nrose;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge({btn_tog, btn_clr, btn_set});
    #1;
    check("model_jk", int'({j, k}), int'(m_jk));
    check("model_busy", int'(busy), int'(m_issue | m_wait));
    check("model_cnt", int'(cmd_count), int'(m_cnt));
    if (j | k) begin
      npulse++;
      lastjk = {j, k};
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_jk", int'({j, k}), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cnt", int'(cmd_count), 0);
    repeat (3) cycle();
    rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic apply_vec(input bit [2:0] btn, input int hold, input int pulses,
                           input bit [1:0] jk, input string name);
    npulse = 0;
    {btn_tog, btn_clr, btn_set} = btn;
    repeat (hold) cycle();
    {btn_tog, btn_clr, btn_set} = 3'b000;
    repeat (20) cycle();
    check({name, "_pulses"}, npulse, pulses);
    if (pulses > 0) check({name, "_jk"}, int'(lastjk), int'(jk));
    exp_cnt = exp_cnt + CW'(pulses);
    check({name, "_cnt"}, int'(cmd_count), int'(exp_cnt));
    check({name, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    vecs[0] = '{3'b001, 20, 1, 2'b10};
    vecs[1] = '{3'b010,  3, 0, 2'b00};
    vecs[2] = '{3'b011, 10, 1, 2'b11};
    vecs[3] = '{3'b100,  6, 1, 2'b11};
    vecs[4] = '{3'b010, 10, 1, 2'b01};
    vecs[5] = '{3'b001,  4, 1, 2'b10};
    vecs[6] = '{3'b001,  3, 0, 2'b00};
    vecs[7] = '{3'b110,  8, 1, 2'b11};
    vecs[8] = '{3'b101,  8, 1, 2'b11};
    wrap_exp = '{1, 2, 3, 0};

    model_reset();
    #1;
    check("reset_jk", int'({j, k}), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_cnt", int'(cmd_count), 0);
    repeat (3) cycle();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Set held 20 cycles: pulse 10 exactly D+3 edges after the first sampling edge.
    btn_set = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      cycle();
      check($sformatf("lat_e%0d", e), int'({j, k}), (e == int'(DB) + 3) ? 2 : 0);
    end
    repeat (12) cycle();
    btn_set = 1'b0;
    repeat (3) cycle();
    check("busy_until_release", int'(busy), 1);
    repeat (10) cycle();
    check("busy_released", int'(busy), 0);
    check("first_cnt", int'(cmd_count), 1);
    exp_cnt = CW'(1);

    for (int i = 0; i < 9; i++)
      apply_vec(vecs[i].btn, vecs[i].hold, vecs[i].pulses, vecs[i].jk, $sformatf("vec%0d", i));

    // Tog pressed while waiting for set release is dropped.
    npulse = 0;
    btn_set = 1'b1;
    repeat (12) cycle();
    btn_tog = 1'b1;
    repeat (10) cycle();
    btn_tog = 1'b0;
    repeat (2) cycle();
    btn_set = 1'b0;
    repeat (20) cycle();
    check("noqueue_pulses", npulse, 1);
    check("noqueue_jk", int'(lastjk), 2);
    exp_cnt = exp_cnt + CW'(1);
    apply_vec(3'b100, 8, 1, 2'b11, "fresh_tog");

    // Counter wraps at 2^CW.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply_vec(3'b001, 8, 1, 2'b10, $sformatf("wrap%0d", i));
      check($sformatf("wrap_seq%0d", i), int'(cmd_count), wrap_exp[i]);
    end

    // Reset during WAIT_RELEASE with set held through release.
    do_reset();
    btn_set = 1'b1;
    repeat (12) cycle();
    check("pre_rst_busy", int'(busy), 1);
    do_reset();
    npulse = 0;
    for (int e = 1; e <= 12; e++) begin
      cycle();
      check($sformatf("rr_lat_e%0d", e), int'({j, k}), (e == int'(DB) + 3) ? 2 : 0);
    end
    btn_set = 1'b0;
    repeat (20) cycle();
    check("rr_pulses", npulse, 1);
    check("rr_cnt", int'(cmd_count), 1);

    // Random button activity against the model.
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 1) == 0) {btn_tog, btn_clr, btn_set} = 3'b000;
      else {btn_tog, btn_clr, btn_set} = 3'($urandom_range(1, 7));
      repeat ($urandom_range(1, 12)) cycle();
    end
    {btn_tog, btn_clr, btn_set} = 3'b000;
    repeat (20) cycle();
    check("rand_idle", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
